nibble_serial_addsub: RTL and testbench
=======================================

Name: nibble_serial_addsub

Overview:
- Multi-cycle 16-bit add/subtract unit for the ALU execute stage.
- Processes one 4-bit nibble per clock through a single internal 4-bit add/sub slice, with a registered carry between nibbles.
- Adds a start/done handshake, optional signed saturation, and N/Z/V flag generation.
- Sits between operand dispatch (upstream) and the flag register and writeback mux (downstream).

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4. Nibble count NIB = WIDTH/4.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when the unit can accept
- A  input  WIDTH  operand A, two's complement
- B  input  WIDTH  operand B, two's complement
- sub  input  1  0 = A+B, 1 = A-B
- sat_en  input  1  1 = saturate the result on signed overflow
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH  final sum/difference; held until the next accepted start
- flag_n  output  1  result[WIDTH-1]
- flag_z  output  1  result == 0
- flag_v  output  1  signed overflow of the raw (unsaturated) operation

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, nibble counter = 0, carry = 0, busy = 0, done = 0, result = 0, flag_n = 0, flag_z = 0, flag_v = 0. Operand registers are cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at edge k latches A, sub and B' (B' = ~B if sub, else B) and sat_en.
  - Carry register loads sub (carry-in 1 for subtract). Counter loads 0. State goes to BUSY.
- BUSY:
  - At each edge, nibble[cnt] = A[cnt] + B'[cnt] + carry.
  - The 4-bit sum is written into a partial-result register at position cnt. Carry-out goes to the carry register. cnt increments.
  - At the edge processing cnt = NIB-1, go to DONE and update result and flags in the same edge.
  - busy = 1 for exactly NIB cycles, from after edge k through edge k+NIB.
- DONE:
  - done = 1 for exactly one cycle, the cycle after edge k+NIB. For WIDTH=16, done is high 4 cycles after acceptance.
  - start=1 in DONE is accepted identically to IDLE (back-to-back operation). Otherwise go to IDLE.
- start in BUSY is ignored. Latched operands stay unchanged; input changes during BUSY have no effect.
- Overflow (raw): V = (~A[MSB] & ~B'[MSB] & S[MSB]) | (A[MSB] & B'[MSB] & ~S[MSB]). S is the raw sum and MSB = WIDTH-1.
- Saturation:
  - Applies when sat_en=1 and V=1.
  - If A[MSB]=0, result = {0, all ones} (0x7FFF).
  - If A[MSB]=1, result = {1, all zeros} (0x8000).
  - Otherwise result = S.
- Flags:
  - flag_n and flag_z are computed from the final (possibly saturated) result.
  - flag_v always reports the raw overflow, even when saturated.
- Final carry-out is discarded. It is not a port.
- result and flags change only at the DONE transition or at reset.
- Reset asserted mid-operation:
  - The operation aborts immediately (asynchronously). All outputs go to their reset values and no done pulse follows.
  - After rst_n deasserts, the unit is in IDLE and accepts start on the first edge.

Test Plan:
- Add: A=0x1234, B=0x0FFF, sub=0, sat_en=0, start at edge k -> busy high 4 cycles; done pulse after edge k+4; result=0x2233, N=0, Z=0, V=0.
- Positive overflow: A=0x7FFF, B=0x0001, sub=0.
  - sat_en=0 -> result=0x8000, N=1, V=1.
  - sat_en=1 -> result=0x7FFF, N=0, V=1.
- Negative overflow: A=0x8000, B=0x0001, sub=1.
  - sat_en=0 -> result=0x7FFF, N=0, V=1.
  - sat_en=1 -> result=0x8000, N=1, V=1.
- Full carry chain: A=0x5555, B=0x5555, sub=1 -> result=0x0000, Z=1, N=0, V=0. A=0xFFFF, B=0x0001, sub=0 -> result=0x0000, Z=1, V=0.
- Handshake:
  - Pulse start with A=0x0001, B=0x0001, then drive start=1 with A=0x1111 during BUSY -> result=0x0002; the second request is ignored.
  - start=1 in the DONE cycle with A=0x0003, B=0x0001, sub=1 -> second done 4 cycles later, result=0x0002.
- Reset mid-op: deassert rst_n during the 2nd BUSY cycle -> busy, done, result and flags go to 0 immediately and no done pulse follows. After release, a new start with A=0x0010, B=0x0020 completes with result=0x0030.

Source files
------------

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle between operand dispatch and the nibble-serial add/sub unit.
interface nibble_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             sat_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output start, A, B, sub, sat_en,
    input  busy, done, result, flag_n, flag_z, flag_v
  );

  modport slave (
    input  start, A, B, sub, sat_en,
    output busy, done, result, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract: one 4-bit slice walks the operands nibble by nibble,
// with a registered carry between nibbles, optional signed saturation and N/Z/V flags.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | one nibble processed per clock, cnt selects the nibble
// DONE  | result/flags valid, done pulse; start here launches the next operation
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_serial_addsub_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtract
  logic             sat_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] part_q;

  logic             accept;
  logic             step;
  logic             last_step;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] sum_next;
  logic             raw_v;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] final_val;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (cnt_q == LAST) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single 4-bit slice plus the full-width view of the sum once this nibble lands.
  always_comb begin
    nib_a    = a_q[{cnt_q, 2'b00} +: 4];
    nib_b    = b_q[{cnt_q, 2'b00} +: 4];
    nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    sum_next = part_q;
    sum_next[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
    raw_v    = (~a_q[MSB] & ~b_q[MSB] &  sum_next[MSB]) |
               ( a_q[MSB] &  b_q[MSB] & ~sum_next[MSB]);
    sat_val  = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    final_val = (sat_q && raw_v) ? sat_val : sum_next;
  end

  // Operand latch and nibble datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.sub ? ~bus.B : bus.B;
      sat_q   <= bus.sat_en;
      carry_q <= bus.sub;
      cnt_q   <= '0;
      part_q  <= '0;
    end else if (step) begin
      part_q  <= sum_next;
      carry_q <= nib_sum[4];
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Result and flags update only when the last nibble completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result <= '0;
      bus.flag_n <= 1'b0;
      bus.flag_z <= 1'b0;
      bus.flag_v <= 1'b0;
    end else if (last_step) begin
      bus.result <= final_val;
      bus.flag_n <= final_val[MSB];
      bus.flag_z <= (final_val == '0);
      bus.flag_v <= raw_v;
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed cases plus random operations,
// checked against a signed-integer arithmetic reference.
module tb_nibble_serial_addsub;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [W-1:0] exp_res;
  logic         exp_n;
  logic         exp_z;
  logic         exp_v;

  nibble_serial_addsub_if #(.WIDTH(W)) bus ();

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic, then clamp or wrap.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic sat);
    longint sa, sb, ex;
    longint maxv, minv;
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ex = s ? (sa - sb) : (sa + sb);
    exp_v = (ex > maxv) || (ex < minv);
    if (sat && exp_v) exp_res = (ex > 0) ? W'(maxv) : W'(minv);
    else              exp_res = W'(ex);
    exp_n = exp_res[W-1];
    exp_z = (exp_res == '0);
  endtask

  // Called at a negedge: present a request and compute its expected outcome.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic sat);
    model(a, b, s, sat);
    bus.A      = a;
    bus.B      = b;
    bus.sub    = s;
    bus.sat_en = sat;
    bus.start  = 1'b1;
  endtask

  // Follows an accepted request to its done pulse; ends at the done negedge
  // when chain=1, otherwise one cycle later with start low.
  task automatic finish_op(input string tag, input logic hold, input logic chain);
    int  nbusy;
    bit  seen;
    nbusy = 0;
    seen  = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) nbusy++;
      if (i == 0) begin
        bus.start = hold;
        if (hold) begin
          bus.A = 16'h1111;
          bus.B = W'($urandom);
        end
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd4);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_nzv"}, {29'd0, bus.flag_n, bus.flag_z, bus.flag_v},
          {29'd0, exp_n, exp_z, exp_v});
    if (!chain) begin
      bus.start = 1'b0;
      @(negedge clk);
      check({tag, "_done_pulse_len"}, 32'(bus.done), 32'd0);
      check({tag, "_result_held"}, 32'(bus.result), 32'(exp_res));
    end
  endtask

  initial begin
    int dones;
    checks = 0;
    errors = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus.sub    = 1'b0;
    bus.sat_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {11'd0, bus.busy, bus.done, bus.result, bus.flag_n, bus.flag_z, bus.flag_v},
          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(16'h1234, 16'h0FFF, 1'b0, 1'b0); finish_op("add", 1'b0, 1'b0);
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op("povf_wrap", 1'b0, 1'b0);
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b1); finish_op("povf_sat", 1'b0, 1'b0);
    launch(16'h8000, 16'h0001, 1'b1, 1'b0); finish_op("novf_wrap", 1'b0, 1'b0);
    launch(16'h8000, 16'h0001, 1'b1, 1'b1); finish_op("novf_sat", 1'b0, 1'b0);
    launch(16'h5555, 16'h5555, 1'b1, 1'b0); finish_op("sub_zero", 1'b0, 1'b0);
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op("carry_chain", 1'b0, 1'b0);
    launch(16'h0000, 16'h8000, 1'b1, 1'b1); finish_op("sub_min_sat", 1'b0, 1'b0);
    launch(16'h0001, 16'h0001, 1'b0, 1'b0); finish_op("ignore_busy_start", 1'b1, 1'b1);
    launch(16'h0003, 16'h0001, 1'b1, 1'b0); finish_op("back_to_back", 1'b0, 1'b0);

    // Abort in the second busy cycle.
    launch(16'h4321, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs",
          {11'd0, bus.busy, bus.done, bus.result, bus.flag_n, bus.flag_z, bus.flag_v},
          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    launch(16'h0010, 16'h0020, 1'b0, 1'b0); finish_op("after_abort", 1'b0, 1'b0);

    // Random operations, biased toward the signed boundaries.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         chain;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      if ($urandom_range(0, 3) == 0) rb = {rb[W-1], rb[W-2:0] | W'(16'h7F00)};
      chain = 1'($urandom_range(0, 1));
      launch(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_op("rand", 1'b0, chain);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
